crank_cam_sim_axil_slave: RTL and testbench
===========================================

CRANK_CAM_SIM_AXIL_SLAVE -- requirements
Module: crank_cam_sim_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: register and data-bus width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width; 4 word registers.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- ACLK  in  1  clock.
- ARESETN  in  1  reset.
REQ-004 SHALL have the following AXI4-Lite write-channel ports:
- s00_axi_awaddr  in  4  write address; s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid  in  1;  s00_axi_awready  out  1.
- s00_axi_wdata  in  32;  s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid  in  1;  s00_axi_wready  out  1.
- s00_axi_bresp  out  2;  s00_axi_bvalid  out  1;  s00_axi_bready  in  1.
REQ-005 SHALL have the following AXI4-Lite read-channel ports:
- s00_axi_araddr  in  4;  s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid  in  1;  s00_axi_arready  out  1.
- s00_axi_rdata  out  32;  s00_axi_rresp  out  2.
- s00_axi_rvalid  out  1;  s00_axi_rready  in  1.
REQ-006 SHALL have the following generator outputs:
- crank_out  out  1  simulated crank tooth signal.
- cam_out  out  1  simulated cam signal.

Function
REQ-007 SHALL provide four fully read/write registers, decoded on addr[3:2]; addr[1:0] ignored:
- REG0 CTRL: bit0 = enable.
- REG1 PERIOD: clocks per tooth.
- REG2 TEETH: [7:0] = total teeth N; [15:8] = missing teeth M.
- REG3 CAM: [7:0] = cam tooth index.
- Every register SHALL read back exactly the value written, all 32 bits included.
REQ-008 Write address and write data SHALL be accepted independently:
- Each is held in a one-entry buffer.
- awready is high when the AW buffer is empty and bvalid is low.
- wready is high when the W buffer is empty and bvalid is low.
REQ-009 When both buffers are full, the register write SHALL occur on that edge with byte granularity per wstrb, and bvalid SHALL assert on the next cycle.
REQ-010 bvalid SHALL hold until bready is sampled high; bresp SHALL always be 2'b00.
REQ-011 arready SHALL be high when rvalid is low.
REQ-012 On an AR handshake, rdata SHALL be registered and rvalid SHALL assert the next cycle; rvalid and rdata SHALL hold stable until rready; rresp SHALL always be 2'b00.
REQ-013 A read and a write to the same register completing on the same edge SHALL return the pre-write value.
REQ-014 The generator SHALL run when CTRL[0]=1, PERIOD≠0 and N≠0; otherwise it is idle, with the counters below cleared and crank_out = cam_out = 0.
REQ-015 Tooth counter tcnt SHALL count 0..PERIOD-1 every clock.
- When tcnt ≥ PERIOD-1 it SHALL wrap to 0, so a shrunk PERIOD wraps immediately.
- On each wrap, tooth index tidx SHALL increment.
REQ-016 tidx SHALL wrap from N-1 to 0; on each tidx wrap, the revolution flag rev SHALL toggle (720° cam cycle).
REQ-017 crank_out SHALL be 1 iff tcnt < PERIOD>>1 and tidx < N-M.
- If M ≥ N, crank_out SHALL stay 0.
- If PERIOD = 1, crank_out SHALL stay 0.
REQ-018 cam_out SHALL be 1 iff rev = 1 and tidx = CAM[7:0].
REQ-019 crank_out and cam_out SHALL be registered outputs with one clock latency from tcnt/tidx.
REQ-020 Writes to PERIOD, TEETH or CAM while running SHALL take effect on the next clock without restarting counters.
- If tidx ≥ a newly written N, tidx SHALL wrap to 0 on the next tooth wrap.

Reset
REQ-021 While ARESETN=0, the block SHALL asynchronously force:
- all registers, buffers, tcnt, tidx and rev to 0.
- awready, wready, arready, bvalid, rvalid, crank_out and cam_out to 0.
REQ-022 Ready outputs SHALL rise on the first ACLK edge after ARESETN deasserts.
REQ-023 Reset mid-transaction SHALL discard the pending write or read; no B or R beat SHALL be issued for it.

Verification
REQ-024 Bench SHALL cover: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four -> same values, bresp = rresp = 0.
REQ-025 Bench SHALL cover: W valid 3 cycles before AW, wstrb=4'b0010, data 0xAABBCCDD to 0x4 preset 0 -> single B; readback 0x0000CC00.
REQ-026 Bench SHALL cover: bready held low 10 cycles -> bvalid held, awready/wready low; rready held low -> rdata stable.
REQ-027 Bench SHALL cover: PERIOD=10, N=12, M=2, CAM=3, enable -> crank_out high 5 of 10 clocks for teeth 0..9, low for teeth 10..11; cam_out high 10 clocks on tooth 3 of every second revolution only.
REQ-028 Bench SHALL cover: clear enable mid-tooth -> next cycle counters 0 and outputs 0; re-enable -> restart at tidx 0, rev 0.
REQ-029 Bench SHALL cover: ARESETN pulsed low during pending bvalid -> bvalid 0, all registers read back 0 after release.

Source files
------------

// File: rtl/crank_cam_sim_axil_slave.sv
// AXI4-Lite register slave driving a crank/cam tooth-wheel signal generator.
// Four R/W registers: CTRL, PERIOD, TEETH (N, M missing), CAM tooth index.
module crank_cam_sim_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              crank_out,
  output logic                              cam_out
);

  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [DATA_W-1:0] ONE_W = 1;

  logic [DATA_W-1:0] regs [4];
  logic              rdy_en;
  logic              aw_full;
  logic              w_full;
  logic [1:0]        aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              bvalid_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] tcnt;
  logic [7:0]        tidx;
  logic              rev;

  logic              unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // rdy_en keeps every ready low until the first edge after reset release
  assign s00_axi_awready = rdy_en & ~aw_full & ~bvalid_q;
  assign s00_axi_wready  = rdy_en & ~w_full & ~bvalid_q;
  assign s00_axi_arready = rdy_en & ~rvalid_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en   <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[3:2];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (aw_full && w_full) begin
        for (int i = 0; i < STRB_W; i++)
          if (w_strb[i]) regs[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      // Nonblocking read of regs returns the pre-write value on a same-edge write
      if (s00_axi_arvalid && s00_axi_arready) begin
        rdata_q  <= regs[s00_axi_araddr[3:2]];
        rvalid_q <= 1'b1;
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  logic [DATA_W-1:0] period;
  logic [7:0]        n_teeth;
  logic [7:0]        m_teeth;
  logic [7:0]        cam_idx;
  logic              run;
  logic              crank_on;
  logic              cam_on;

  assign period   = regs[1];
  assign n_teeth  = regs[2][7:0];
  assign m_teeth  = regs[2][15:8];
  assign cam_idx  = regs[3][7:0];
  assign run      = regs[0][0] && (period != '0) && (n_teeth != 8'd0);
  assign crank_on = (tcnt < (period >> 1)) && (m_teeth < n_teeth) &&
                    (tidx < (n_teeth - m_teeth));
  assign cam_on   = rev && (tidx == cam_idx);

  // Generator: >= compares let a shrunk PERIOD or N wrap at the next opportunity
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tcnt      <= '0;
      tidx      <= 8'd0;
      rev       <= 1'b0;
      crank_out <= 1'b0;
      cam_out   <= 1'b0;
    end else if (!run) begin
      tcnt      <= '0;
      tidx      <= 8'd0;
      rev       <= 1'b0;
      crank_out <= 1'b0;
      cam_out   <= 1'b0;
    end else begin
      crank_out <= crank_on;
      cam_out   <= cam_on;
      if (tcnt >= period - ONE_W) begin
        tcnt <= '0;
        if (tidx >= n_teeth - 8'd1) begin
          tidx <= 8'd0;
          rev  <= ~rev;
        end else begin
          tidx <= tidx + 8'd1;
        end
      end else begin
        tcnt <= tcnt + ONE_W;
      end
    end
  end

endmodule

// File: tb/tb_crank_cam_sim_axil_slave.sv
// Self-checking bench for crank_cam_sim_axil_slave: AXI-Lite register access
// and the tooth-wheel generator against a closed-form reference model.
module tb_crank_cam_sim_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        crank_out, cam_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [4];

  always #5 ACLK = ~ACLK;

  crank_cam_sim_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .crank_out(crank_out), .cam_out(cam_out)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Expected {crank, cam} j cycles into a run, from wheel position arithmetic
  function automatic logic [1:0] gen_ref(input int j, input int p, input int n,
                                         input int m, input int c);
    int phase, tooth, rv;
    logic cr, cm;
    if (p == 0 || n == 0) return 2'b00;
    phase = j % p;
    tooth = (j / p) % n;
    rv    = (j / (p * n)) % 2;
    cr = (phase < p / 2) && (m < n) && (tooth < n - m);
    cm = (rv == 1) && (tooth == c);
    return {cr, cm};
  endfunction

  task automatic write_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_delay, output bit ok);
    bit aw_hs, w_hs;
    int cyc;
    @(negedge ACLK);
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = 1'b0;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 100) begin
      if (cyc == aw_delay) awvalid = 1'b1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge ACLK);
      @(negedge ACLK);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      ok = bvalid;
      cyc++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic b_accept();
    bready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    bready = 1'b0;
  endtask

  task automatic read_issue(input logic [3:0] a, output bit ok);
    bit hs;
    int cyc;
    @(negedge ACLK);
    araddr = a; arvalid = 1'b1; ok = 1'b0; cyc = 0;
    while (!ok && cyc < 100) begin
      hs = arvalid && arready;
      @(posedge ACLK);
      @(negedge ACLK);
      if (hs) arvalid = 1'b0;
      ok = rvalid;
      cyc++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
      arvalid = 1'b0;
    end
  endtask

  task automatic r_accept();
    rready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_delay, output logic [1:0] resp);
    bit ok;
    write_issue(a, d, s, aw_delay, ok);
    resp = bresp;
    if (ok) b_accept();
    model_regs[a[3:2]] = merge(model_regs[a[3:2]], d, s);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok;
    read_issue(a, ok);
    d = rdata;
    resp = rresp;
    if (ok) r_accept();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, crank_out, cam_out} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required 0000000",
               {awready, wready, arready, bvalid, rvalid, crank_out, cam_out});
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_edge got=%b required 000", {awready, wready, arready});
    end
    @(negedge ACLK);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_edge got=%b required 111", {awready, wready, arready});
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h required 00000000", i, d);
      end
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hf, 0, r);
      checks++;
      if (r !== 2'b00) begin errors++; $display("FAIL bresp_reg%0d got=%b required 00", i, r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      checks++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        errors++;
        $display("FAIL basic_read_reg%0d got=%h resp=%b required %h resp=00", i, d, r, i + 1);
      end
    end
  endtask

  task automatic test_wstrb_w_first();
    logic [31:0] d;
    logic [1:0]  r;
    int bcnt;
    axi_write(4'h4, 32'h0, 4'hf, 0, r);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010, 3, r);
    bcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      if (bvalid) bcnt++;
    end
    checks++;
    if (bcnt != 0) begin errors++; $display("FAIL extra_b got=%0d required 0", bcnt); end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0000CC00 || d !== model_regs[1]) begin
      errors++;
      $display("FAIL wstrb_readback got=%h required 0000cc00", d);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] held;
    write_issue(4'hC, 32'h5A5A1234, 4'hf, 0, ok);
    model_regs[3] = 32'h5A5A1234;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bvalid, awready, wready} !== 3'b100) begin
        errors++;
        $display("FAIL b_hold cyc=%0d bvalid,awready,wready=%b required 100", k,
                 {bvalid, awready, wready});
      end
      @(negedge ACLK);
    end
    b_accept();
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_release got=%b required 0", bvalid); end
    read_issue(4'hC, ok);
    held = rdata;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      checks++;
      if (rvalid !== 1'b1 || rdata !== held || held !== 32'h5A5A1234) begin
        errors++;
        $display("FAIL r_hold cyc=%0d rvalid=%b rdata=%h required 1 5a5a1234", k, rvalid, rdata);
      end
    end
    r_accept();
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(4'h8, 32'h11111111, 4'hf, 0, r);
    @(negedge ACLK);
    awaddr = 4'h8; wdata = 32'h22222222; wstrb = 4'hf; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0; araddr = 4'h8; arvalid = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL same_edge rvalid=%b bvalid=%b rdata=%h required 1 1 11111111",
               rvalid, bvalid, rdata);
    end
    rready = 1'b1; bready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    rready = 1'b0; bready = 1'b0;
    model_regs[2] = 32'h22222222;
    axi_read(4'h8, d, r);
    checks++;
    if (d !== model_regs[2]) begin errors++; $display("FAIL same_edge_after got=%h required %h", d, model_regs[2]); end
  endtask

  task automatic test_random_rw();
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  a;
    for (int i = 0; i < 16; i++) begin
      a = 4'($urandom_range(0, 15));
      axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), r);
      a = 4'($urandom_range(0, 15));
      axi_read(a, d, r);
      checks++;
      if (d !== model_regs[a[3:2]] || r !== 2'b00) begin
        errors++;
        $display("FAIL random_read addr=%h got=%h resp=%b required %h resp=00",
                 a, d, r, model_regs[a[3:2]]);
      end
    end
  endtask

  task automatic enable_and_check(input int p, input int n, input int m, input int c,
                                  input int cycles);
    bit ok;
    logic [1:0] exp;
    int errs;
    errs = 0;
    write_issue(4'h0, 32'h1, 4'hf, 0, ok);
    model_regs[0] = 32'h1;
    bready = 1'b1;
    for (int j = 0; j < cycles && errs < 5; j++) begin
      @(negedge ACLK);
      bready = 1'b0;
      exp = gen_ref(j, p, n, m, c);
      checks++;
      if ({crank_out, cam_out} !== exp) begin
        errors++; errs++;
        $display("FAIL gen P=%0d N=%0d M=%0d C=%0d j=%0d crank,cam=%b required %b",
                 p, n, m, c, j, {crank_out, cam_out}, exp);
      end
    end
  endtask

  task automatic configure(input int p, input int n, input int m, input int c);
    logic [1:0] r;
    axi_write(4'h0, 32'h0, 4'hf, 0, r);
    axi_write(4'h4, 32'(p), 4'hf, 0, r);
    axi_write(4'h8, {16'h0, 8'(m), 8'(n)}, 4'hf, 0, r);
    axi_write(4'hC, 32'(c), 4'hf, 0, r);
  endtask

  task automatic test_generator();
    int p, n, m, c;
    configure(10, 12, 2, 3);
    enable_and_check(10, 12, 2, 3, 260);
    for (int i = 0; i < 5; i++) begin
      p = $urandom_range(1, 6);
      n = $urandom_range(1, 8);
      m = $urandom_range(0, 9);
      c = $urandom_range(0, 9);
      configure(p, n, m, c);
      enable_and_check(p, n, m, c, 2 * p * n + 10);
    end
  endtask

  task automatic test_disable();
    bit ok;
    int bad;
    configure(10, 12, 2, 3);
    enable_and_check(10, 12, 2, 3, 137);
    write_issue(4'h0, 32'h0, 4'hf, 0, ok);
    model_regs[0] = 32'h0;
    bready = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge ACLK);
      bready = 1'b0;
      if (crank_out !== 1'b0 || cam_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL disable_outputs nonzero_cycles=%0d required 0", bad); end
    enable_and_check(10, 12, 2, 3, 260);
  endtask

  task automatic test_reset_pending();
    bit ok;
    logic [31:0] d;
    logic [1:0]  r;
    int bcnt;
    axi_write(4'h4, 32'hCAFEF00D, 4'hf, 0, r);
    write_issue(4'hC, 32'h12345678, 4'hf, 0, ok);
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if ({bvalid, awready, wready, arready, crank_out, cam_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got=%b required 000000",
               {bvalid, awready, wready, arready, crank_out, cam_out});
    end
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    bready = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    bcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      if (bvalid) bcnt++;
    end
    bready = 1'b0;
    checks++;
    if (bcnt != 0) begin errors++; $display("FAIL reset_b_dropped got=%0d required 0", bcnt); end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      checks++;
      if (d !== model_regs[i]) begin
        errors++;
        $display("FAIL reset_clear_reg%0d got=%h required %h", i, d, model_regs[i]);
      end
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    repeat (3) @(negedge ACLK);
    test_reset();
    test_basic_rw();
    test_wstrb_w_first();
    test_backpressure();
    test_same_edge();
    test_random_rw();
    test_generator();
    test_disable();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
